// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the wb_dma_burst engine.
//   - Register window offsets (low five address bits inside the 32-byte window)
//   - MODE encodings written to CTRL[2:1]
//   - Transfer FSM state type
package dma_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_SRC    = 5'h08;
    localparam logic [4:0] OFF_DST    = 5'h0C;
    localparam logic [4:0] OFF_LEN    = 5'h10;
    localparam logic [4:0] OFF_COUNT  = 5'h14;

    // Mode 3 is reserved and behaves like memory-to-memory.
    localparam logic [1:0] MODE_MEM2PER = 2'd0;
    localparam logic [1:0] MODE_PER2MEM = 2'd1;
    localparam logic [1:0] MODE_MEM2MEM = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: single-clock first-word-fall-through FIFO used as the
// burst buffer between the read and write phases of the DMA.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   flush           empty the FIFO immediately (abort path)
//   push, din       write one word when not full
//   pop             discard the head word when not empty
//   dout            current head word (valid whenever empty is low)
//   full, empty     occupancy flags
module dma_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths would also work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        ptr_inc = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == (AW + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head is read combinationally so the word is visible without a pop.
    assign dout    = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/wb_dma_burst.sv
// wb_dma_burst: Wishbone DMA engine. The CPU programs SRC/DST/LEN/CTRL
// through a 32-byte slave register window; the engine then moves LEN words
// over a Wishbone classic master port, reading up to BURST words into a
// FIFO and then draining them, until all words are written.
// Optional build macro: DMA_IRQ_EN -- when defined, CTRL[3] is an RW
// ERR_MASK bit and irq = DONE & ~ERR_MASK; otherwise irq is tied low.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_stb/s_cyc/s_we/s_sel   CPU slave request (s_sel ignored)
//   s_adr, s_dat_i           slave address / write data
//   s_ack, s_dat_o           one-cycle slave acknowledge / read data
//   m_stb/m_cyc/m_we/m_sel   master request (m_sel = F while m_cyc)
//   m_adr, m_dat_o           master address / write data
//   m_ack, m_dat_i           master acknowledge / read data
//   busy                     transfer in progress (FSM not IDLE)
//   irq                      done interrupt
module wb_dma_burst
    import dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0080,
    parameter int          BURST     = 8,
    parameter int          LEN_W     = 16,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_stb,
    input  logic        s_cyc,
    input  logic        s_we,
    input  logic [3:0]  s_sel,
    input  logic [31:0] s_adr,
    input  logic [31:0] s_dat_i,
    output logic        s_ack,
    output logic [31:0] s_dat_o,
    output logic        m_stb,
    output logic        m_cyc,
    output logic        m_we,
    output logic [3:0]  m_sel,
    output logic [31:0] m_adr,
    output logic [31:0] m_dat_o,
    input  logic        m_ack,
    input  logic [31:0] m_dat_i,
    output logic        busy,
    output logic        irq
);

    localparam int CW = $clog2(BURST) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    dma_state_e       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [31:0]      rd_ptr_q, rd_ptr_d;
    logic [31:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic             m_stb_q, m_stb_d;
    logic             m_we_q, m_we_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             s_ack_q, s_ack_d;
    logic [31:0]      s_dat_q, s_dat_d;
`ifdef DMA_IRQ_EN
    logic             err_mask_q, err_mask_d;
`endif

    logic             hit, wr_en, start;
    logic [4:0]       off;
    logic [31:0]      rdata, ctrl_rd;
    logic [LEN_W-1:0] remaining;
    logic [CW-1:0]    chunk;
    logic             tmo_expire;
    logic             fifo_push, fifo_pop, fifo_flush;
    logic             fifo_full, fifo_empty;
    logic [31:0]      fifo_head;
    logic             unused_ok;

    assign unused_ok = ^{s_sel, fifo_full};

    dma_sync_fifo #(
        .WIDTH (32),
        .DEPTH (BURST)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (m_dat_i),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy    = (state_q != IDLE);
    assign s_ack   = s_ack_q;
    assign s_dat_o = s_dat_q;
    assign m_stb   = m_stb_q;
    assign m_cyc   = m_stb_q;
    assign m_we    = m_we_q;
    assign m_sel   = m_stb_q ? 4'hF : 4'h0;
    assign m_adr   = m_stb_q ? (m_we_q ? wr_ptr_q : rd_ptr_q) : 32'h0;
    assign m_dat_o = (m_stb_q && m_we_q) ? fifo_head : 32'h0;

`ifdef DMA_IRQ_EN
    assign irq     = done_q & ~err_mask_q;
    assign ctrl_rd = {28'h0, err_mask_q, mode_q, 1'b0};
`else
    assign irq     = 1'b0;
    assign ctrl_rd = {29'h0, mode_q, 1'b0};
`endif

    assign hit       = (s_adr[31:5] == BASE_ADDR[31:5]);
    assign off       = s_adr[4:0];
    // COUNT is constant during READ, so the chunk size can be derived live.
    assign remaining = len_q - count_q;
    assign chunk     = (remaining >= LEN_W'(BURST)) ? CW'(BURST) : CW'(remaining);
    assign tmo_expire = m_stb_q && !m_ack && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        case (off)
            OFF_CTRL:   rdata = ctrl_rd;
            OFF_STATUS: rdata = {29'h0, err_q, done_q, busy};
            OFF_SRC:    rdata = src_q;
            OFF_DST:    rdata = dst_q;
            OFF_LEN:    rdata = 32'(len_q);
            OFF_COUNT:  rdata = 32'(count_q);
            default:    rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        done_d     = done_q;
        err_d      = err_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_cnt_d   = rd_cnt_q;
        m_stb_d    = m_stb_q;
        m_we_d     = m_we_q;
        tmo_d      = tmo_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        start      = 1'b0;
`ifdef DMA_IRQ_EN
        err_mask_d = err_mask_q;
`endif

        // Slave side: ack the cycle after a request is seen; the register
        // update lands on the same edge that raises s_ack.
        s_ack_d = s_stb & s_cyc & ~s_ack_q;
        wr_en   = s_ack_d & s_we & hit;
        s_dat_d = (s_ack_d && !s_we && hit) ? rdata : 32'h0;

        if (wr_en) begin
            case (off)
                OFF_CTRL: if (!busy) begin
                    mode_d = s_dat_i[2:1];
                    start  = s_dat_i[0];
`ifdef DMA_IRQ_EN
                    err_mask_d = s_dat_i[3];
`endif
                end
                OFF_STATUS: begin
                    if (s_dat_i[1]) done_d = 1'b0;
                    if (s_dat_i[2]) err_d  = 1'b0;
                end
                OFF_SRC: if (!busy) src_d = s_dat_i;
                OFF_DST: if (!busy) dst_d = s_dat_i;
                OFF_LEN: if (!busy) len_d = s_dat_i[LEN_W-1:0];
                default: ;
            endcase
        end

        if (start) begin
            if (len_q == '0) begin
                done_d = 1'b1;
            end else begin
                count_d  = '0;
                rd_ptr_d = src_q;
                wr_ptr_d = dst_q;
                rd_cnt_d = '0;
                done_d   = 1'b0;
                err_d    = 1'b0;
                state_d  = READ;
            end
        end

        // Master side. Hardware status updates come after the W1C handling
        // so a set on the same edge wins over a CPU clear.
        if (m_stb_q && !m_ack) tmo_d = tmo_q + 1'b1;

        if ((state_q == READ || state_q == WRITE) && tmo_expire) begin
            m_stb_d    = 1'b0;
            m_we_d     = 1'b0;
            err_d      = 1'b1;
            done_d     = 1'b1;
            fifo_flush = 1'b1;
            state_d    = IDLE;
        end else begin
            case (state_q)
                READ: begin
                    if (m_stb_q) begin
                        if (m_ack) begin
                            fifo_push = 1'b1;
                            m_stb_d   = 1'b0;
                            rd_cnt_d  = rd_cnt_q + 1'b1;
                            if (mode_q != MODE_PER2MEM) rd_ptr_d = rd_ptr_q + 32'd4;
                            if ((rd_cnt_q + 1'b1) == chunk) state_d = WRITE;
                        end
                    end else begin
                        m_stb_d = 1'b1;
                        m_we_d  = 1'b0;
                        tmo_d   = '0;
                    end
                end
                WRITE: begin
                    if (m_stb_q) begin
                        if (m_ack) begin
                            fifo_pop = 1'b1;
                            m_stb_d  = 1'b0;
                            m_we_d   = 1'b0;
                            count_d  = count_q + 1'b1;
                            if (mode_q != MODE_MEM2PER) wr_ptr_d = wr_ptr_q + 32'd4;
                        end
                    end else if (fifo_empty) begin
                        rd_cnt_d = '0;
                        state_d  = (count_q == len_q) ? FINISH : READ;
                    end else begin
                        m_stb_d = 1'b1;
                        m_we_d  = 1'b1;
                        tmo_d   = '0;
                    end
                end
                FINISH: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            m_stb_q    <= 1'b0;
            m_we_q     <= 1'b0;
            tmo_q      <= '0;
            s_ack_q    <= 1'b0;
            s_dat_q    <= '0;
`ifdef DMA_IRQ_EN
            err_mask_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            err_q      <= err_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            m_stb_q    <= m_stb_d;
            m_we_q     <= m_we_d;
            tmo_q      <= tmo_d;
            s_ack_q    <= s_ack_d;
            s_dat_q    <= s_dat_d;
`ifdef DMA_IRQ_EN
            err_mask_q <= err_mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_dma_burst.sv
module tb_wb_dma_burst;

    localparam logic [31:0] A_CTRL   = 32'h3000_0080;
    localparam logic [31:0] A_STATUS = 32'h3000_0084;
    localparam logic [31:0] A_SRC    = 32'h3000_0088;
    localparam logic [31:0] A_DST    = 32'h3000_008C;
    localparam logic [31:0] A_LEN    = 32'h3000_0090;
    localparam logic [31:0] A_COUNT  = 32'h3000_0094;
    localparam int          TIMEOUT  = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_stb, s_cyc, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat_i;
    logic        s_ack;
    logic [31:0] s_dat_o;
    logic        m_stb, m_cyc, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat_o;
    logic        m_ack   = 1'b0;
    logic [31:0] m_dat_i = 32'h0;
    logic        busy, irq;

    always #5 clk = ~clk;

    wb_dma_burst dut (
        .clk     (clk),
        .rst     (rst),
        .s_stb   (s_stb),
        .s_cyc   (s_cyc),
        .s_we    (s_we),
        .s_sel   (s_sel),
        .s_adr   (s_adr),
        .s_dat_i (s_dat_i),
        .s_ack   (s_ack),
        .s_dat_o (s_dat_o),
        .m_stb   (m_stb),
        .m_cyc   (m_cyc),
        .m_we    (m_we),
        .m_sel   (m_sel),
        .m_adr   (m_adr),
        .m_dat_o (m_dat_o),
        .m_ack   (m_ack),
        .m_dat_i (m_dat_i),
        .busy    (busy),
        .irq     (irq)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bus-side model: RAM at 0x38xx_xxxx returns word index + 1,
    // anything else acts as a peripheral returning a sequence 0xA000_0000+n.
    logic [31:0] rd_adr_log [256];
    logic [31:0] wr_adr_log [256];
    logic [31:0] wr_dat_log [256];
    bit          op_log     [512];
    int  n_rd = 0, n_wr = 0, n_op = 0, cyc_cnt = 0, stall_cnt = 0;
    int  periph_seq = 0, sel_bad = 0;
    bit  stall_en = 1'b0;
    int  stall_idx = 0;

    always @(negedge clk) begin
        if (m_cyc) begin
            cyc_cnt++;
            if (m_sel !== 4'hF) sel_bad++;
        end
        if (m_ack) begin
            m_ack = 1'b0;
        end else if (m_stb && m_cyc && !rst) begin
            if (m_we && stall_en && n_wr == stall_idx) begin
                stall_cnt++;
            end else begin
                m_ack = 1'b1;
                if (m_we) begin
                    wr_adr_log[n_wr[7:0]] = m_adr;
                    wr_dat_log[n_wr[7:0]] = m_dat_o;
                    n_wr++;
                    op_log[n_op[8:0]] = 1'b1;
                    $display("MW adr=%h dat=%h", m_adr, m_dat_o);
                end else begin
                    rd_adr_log[n_rd[7:0]] = m_adr;
                    if (m_adr[31:24] == 8'h38) begin
                        m_dat_i = ((m_adr - 32'h3800_0000) >> 2) + 32'd1;
                    end else begin
                        m_dat_i = 32'hA000_0000 + 32'(periph_seq);
                        periph_seq++;
                    end
                    n_rd++;
                    op_log[n_op[8:0]] = 1'b0;
                    $display("MR adr=%h dat=%h", m_adr, m_dat_i);
                end
                n_op++;
            end
        end
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        s_adr = a; s_dat_i = d; s_we = 1'b1; s_stb = 1'b1; s_cyc = 1'b1; s_sel = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_ack && n < 20);
        if (!s_ack) check("wb_write_ack_timeout", {31'h0, s_ack}, 32'h1);
        s_stb = 1'b0; s_cyc = 1'b0; s_we = 1'b0;
        $display("CPU WR adr=%h dat=%h", a, d);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        s_adr = a; s_we = 1'b0; s_stb = 1'b1; s_cyc = 1'b1; s_sel = 4'hF;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_ack && n < 20);
        if (!s_ack) check("wb_read_ack_timeout", {31'h0, s_ack}, 32'h1);
        d = s_dat_o;
        s_stb = 1'b0; s_cyc = 1'b0;
        $display("CPU RD adr=%h dat=%h", a, d);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin @(negedge clk); n++; end
        check(tag, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int r0, w0, o0, c0, p0, idx;
        int chunks [3];

        rst = 1'b1; s_stb = 1'b0; s_cyc = 1'b0; s_we = 1'b0; s_sel = 4'h0;
        s_adr = 32'h0; s_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_irq",  {31'h0, irq},  32'h0);
        check("rst_mcyc", {31'h0, m_cyc}, 32'h0);
        check("rst_madr", m_adr, 32'h0);
        check("rst_sack", {31'h0, s_ack}, 32'h0);
        wb_read(A_STATUS, rd); check("rst_status", rd, 32'h0);
        wb_read(A_SRC, rd);    check("rst_src", rd, 32'h0);

        // T1: mem->per, LEN=5
        r0 = n_rd; w0 = n_wr;
        wb_write(A_SRC, 32'h3800_0000);
        wb_write(A_DST, 32'h3000_0000);
        wb_write(A_LEN, 32'd5);
        wb_write(A_CTRL, 32'h1);
        wait_idle("t1_idle", 500);
        check("t1_nrd", 32'(n_rd - r0), 32'd5);
        check("t1_nwr", 32'(n_wr - w0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1_rd_adr%0d", i), rd_adr_log[r0 + i], 32'h3800_0000 + 32'(4 * i));
            check($sformatf("t1_wr_adr%0d", i), wr_adr_log[w0 + i], 32'h3000_0000);
            check($sformatf("t1_wr_dat%0d", i), wr_dat_log[w0 + i], 32'(i + 1));
        end
        wb_read(A_STATUS, rd); check("t1_status", rd, 32'h2);
        wb_read(A_COUNT, rd);  check("t1_count", rd, 32'd5);
        wb_read(A_CTRL, rd);   check("t1_ctrl", rd, 32'h0);
`ifdef DMA_IRQ_EN
        check("t1_irq", {31'h0, irq}, 32'h1);
`else
        check("t1_irq", {31'h0, irq}, 32'h0);
`endif

        // T2: mem->mem, LEN=20, chunks 8/8/4
        r0 = n_rd; w0 = n_wr; o0 = n_op;
        wb_write(A_DST, 32'h3800_1000);
        wb_write(A_LEN, 32'd20);
        wb_write(A_CTRL, 32'h5);
        wait_idle("t2_idle", 2000);
        check("t2_total", 32'(n_op - o0), 32'd40);
        chunks = '{8, 8, 4};
        idx = o0;
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < chunks[c]; j++) begin
                check($sformatf("t2_op%0d_rd", idx - o0), {31'h0, op_log[idx]}, 32'h0);
                idx++;
            end
            for (int j = 0; j < chunks[c]; j++) begin
                check($sformatf("t2_op%0d_wr", idx - o0), {31'h0, op_log[idx]}, 32'h1);
                idx++;
            end
        end
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t2_wr_adr%0d", i), wr_adr_log[w0 + i], 32'h3800_1000 + 32'(4 * i));
            check($sformatf("t2_wr_dat%0d", i), wr_dat_log[w0 + i], 32'(i + 1));
        end
        wb_read(A_COUNT, rd); check("t2_count", rd, 32'd20);
        wb_read(A_LEN, rd);   check("t2_len", rd, 32'd20);
        wb_read(A_CTRL, rd);  check("t2_ctrl", rd, 32'h4);

        // T3: per->mem, LEN=3, fixed source
        r0 = n_rd; w0 = n_wr; p0 = periph_seq;
        wb_write(A_SRC, 32'h3000_0040);
        wb_write(A_DST, 32'h3800_0100);
        wb_write(A_LEN, 32'd3);
        wb_write(A_CTRL, 32'h3);
        wait_idle("t3_idle", 500);
        check("t3_nrd", 32'(n_rd - r0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_rd_adr%0d", i), rd_adr_log[r0 + i], 32'h3000_0040);
            check($sformatf("t3_wr_adr%0d", i), wr_adr_log[w0 + i], 32'h3800_0100 + 32'(4 * i));
            check($sformatf("t3_wr_dat%0d", i), wr_dat_log[w0 + i], 32'hA000_0000 + 32'(p0 + i));
        end

        // T4: DONE W1C, then LEN=0 start
        wb_write(A_STATUS, 32'h2);
        wb_read(A_STATUS, rd); check("t4_w1c", rd, 32'h0);
        c0 = cyc_cnt;
        wb_write(A_LEN, 32'd0);
        wb_write(A_CTRL, 32'h1);
        wb_read(A_STATUS, rd); check("t4_status", rd, 32'h2);
        repeat (10) @(negedge clk);
        check("t4_no_mcyc", 32'(cyc_cnt - c0), 32'd0);

        // T5: timeout on the second write word, then restart
        w0 = n_wr;
        wb_write(A_SRC, 32'h3800_0000);
        wb_write(A_DST, 32'h3800_0200);
        wb_write(A_LEN, 32'd2);
        stall_idx = n_wr + 1; stall_cnt = 0; stall_en = 1'b1;
        wb_write(A_CTRL, 32'h5);
        wait_idle("t5_idle", 3000);
        stall_en = 1'b0;
        check("t5_stall_cycles", 32'(stall_cnt), 32'(TIMEOUT));
        check("t5_mcyc", {31'h0, m_cyc}, 32'h0);
        wb_read(A_STATUS, rd); check("t5_status", rd, 32'h6);
        wb_read(A_COUNT, rd);  check("t5_count", rd, 32'd1);
        w0 = n_wr;
        wb_write(A_CTRL, 32'h5);
        wait_idle("t5_re_idle", 500);
        wb_read(A_STATUS, rd); check("t5_re_status", rd, 32'h2);
        wb_read(A_COUNT, rd);  check("t5_re_count", rd, 32'd2);
        check("t5_re_dat0", wr_dat_log[w0], 32'd1);
        check("t5_re_dat1", wr_dat_log[w0 + 1], 32'd2);

        // T6: write while busy, then reset mid-WRITE
        wb_write(A_LEN, 32'd20);
        wb_write(A_CTRL, 32'h5);
        check("t6_busy", {31'h0, busy}, 32'h1);
        wb_write(A_SRC, 32'hDEAD_BEEC);
        wb_read(A_SRC, rd); check("t6_src_locked", rd, 32'h3800_0000);
        idx = 0;
        while (!(m_stb && m_we) && idx < 500) begin @(negedge clk); idx++; end
        check("t6_in_write", {31'h0, m_we}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_mcyc", {31'h0, m_cyc}, 32'h0);
        check("t6_rst_mstb", {31'h0, m_stb}, 32'h0);
        check("t6_rst_mwe",  {31'h0, m_we},  32'h0);
        check("t6_rst_madr", m_adr, 32'h0);
        check("t6_rst_mdat", m_dat_o, 32'h0);
        check("t6_rst_msel", {28'h0, m_sel}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_irq",  {31'h0, irq}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        c0 = cyc_cnt;
        repeat (5) @(negedge clk);
        check("t6_post_rst_quiet", 32'(cyc_cnt - c0), 32'd0);
        wb_read(A_SRC, rd);    check("t6_post_rst_src", rd, 32'h0);
        wb_read(A_STATUS, rd); check("t6_post_rst_status", rd, 32'h0);
        check("m_sel_while_cyc", 32'(sel_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
